pc_unit_ras: RTL and testbench
==============================

Name: pc_unit_ras

Overview:
Parametrised program counter for the ARM pipeline. It adds stall and branch-with-link, plus a circular return-address stack (RAS) that predicts return targets. It keeps the team's sign-magnitude branch-offset encoding and the direct-write path used by PC-destination writes. It sits at the head of fetch and drives the instruction-memory address.

Parameters:
WIDTH, 32, PC and data width in bits (>= 8).
RAS_DEPTH, 4, return-address stack entries (power of two, >= 2).
PC_STEP, 4, sequential increment.
PIPE_OFFSET, 8, pipeline read-ahead added to the PC on a branch.
RESET_VEC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hold PC and RAS this cycle.
branch  input  1  take branch this cycle.
link  input  1  qualifies branch as branch-with-link (push return address).
ret  input  1  return: next PC = RAS top, pop.
branch_imm  input  WIDTH  sign-magnitude offset; MSB = subtract, [WIDTH-2:0] = magnitude.
write_enable  input  1  load PC from write_data.
write_data  input  WIDTH  direct PC load value.
curr_pc  output  WIDTH  registered current PC.
ras_empty  output  1  RAS holds 0 entries.
ras_full  output  1  RAS holds RAS_DEPTH entries.
ras_overflow  output  1  sticky: a push occurred while full.
ras_underflow  output  1  sticky: a ret occurred while empty.
misalign_err  output  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Reset value of every output:
  - curr_pc = RESET_VEC.
  - ras_empty = 1; RAS count = 0; write pointer = 0.
  - ras_full = 0, ras_overflow = 0, ras_underflow = 0, misalign_err = 0.
- All state updates on the rising edge of clk. curr_pc changes one cycle after the qualifying inputs.
- Next-PC priority, evaluated each cycle:
  1. reset
  2. stall: PC, RAS and sticky flags all hold; branch/ret/write ignored.
  3. branch: next = curr_pc + PIPE_OFFSET + mag, or curr_pc + PIPE_OFFSET - mag when branch_imm MSB = 1.
  4. ret
  5. write_enable: next = write_data.
  6. otherwise: next = curr_pc + PC_STEP.
- All arithmetic is modulo 2^WIDTH; wrap-around is silent.
- Push: branch && link && !stall pushes curr_pc + PC_STEP.
  - link without branch is ignored.
- Pop: ret is honoured only when it wins priority.
  - ret with branch: branch wins, no pop.
  - Non-empty: next = top entry, count decrements.
  - Empty: treated as sequential (curr_pc + PC_STEP), ras_underflow set, count stays 0.
- RAS is circular.
  - Push while not full: write entry, count increments.
  - Push while full: overwrite the oldest entry, count stays RAS_DEPTH, ras_overflow set.
- ras_empty = (count == 0); ras_full = (count == RAS_DEPTH). Both are registered-state derived and valid the cycle after the update.
- Sticky flags clear only on reset.
- Reset mid-sequence discards all RAS contents immediately, regardless of stall.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Any load into the PC (branch target, ret target, write_data) has bits [1:0] forced to 0.
  - misalign_err pulses 1 for one cycle, the cycle after the load, if those bits were nonzero before masking.
- Undefined:
  - Values load verbatim.
  - misalign_err is tied 0.

Test Plan:
- Reset, then 3 idle cycles -> curr_pc = 0x0, 0x4, 0x8, 0xC; ras_empty = 1.
- At curr_pc = 0x100, branch = 1, branch_imm = 0x80000010 -> curr_pc = 0xF8 (0x100 + 8 - 0x10). With branch_imm = 0x10 -> curr_pc = 0x118.
- At curr_pc = 0x200, branch + link, branch_imm = 0x40 -> curr_pc = 0x248, ras_empty = 0. Later ret -> curr_pc = 0x204, ras_empty = 1.
- RAS_DEPTH = 4: five linked branches from PCs A..E, then five rets:
  - ras_overflow = 1.
  - Returns E+4, D+4, C+4, B+4 in order.
  - Fifth ret goes sequential with ras_underflow = 1.
- Simultaneous branch, ret, write_enable (write_data = 0x500) at curr_pc = 0x300, branch_imm = 0 -> curr_pc = 0x308; RAS count unchanged.
- stall = 1 with branch + link asserted for 2 cycles -> curr_pc unchanged, no push. Then reset asserted under stall -> curr_pc = RESET_VEC.
- With PC_ALIGN_CHECK_EN, write_data = 0x403 -> curr_pc = 0x400, misalign_err pulses once.

Source files
------------

// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - program counter with stall, branch-with-link and circular return-address stack
//
// Purpose:
//   Fetch-stage program counter. Each cycle the next PC is chosen by priority:
//   reset, stall (hold everything), branch (sign-magnitude offset from
//   curr_pc + PIPE_OFFSET), ret (pop RAS top), write_enable (direct load),
//   otherwise sequential curr_pc + PC_STEP. A linked branch pushes the return
//   address curr_pc + PC_STEP onto a circular RAS; pushing while full
//   overwrites the oldest entry.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   When defined, every load into the PC (branch target, ret target,
//   write_data) has bits [1:0] cleared and misalign_err pulses the cycle
//   after a load whose low bits were nonzero. When undefined, loads are
//   verbatim and misalign_err is tied 0.
//
// Ports:
//   clk, reset      clock (rising edge), synchronous active-high reset
//   stall           hold PC, RAS and sticky flags
//   branch, link    take branch; link additionally pushes a return address
//   ret             pop RAS top into the PC
//   branch_imm      sign-magnitude offset (MSB = subtract)
//   write_enable    load PC from write_data
//   curr_pc         registered PC
//   ras_empty/full  RAS occupancy status
//   ras_overflow    sticky: push while full
//   ras_underflow   sticky: ret while empty
//   misalign_err    one-cycle pulse (alignment check build only)

module pc_unit_ras #(
  parameter int               WIDTH       = 32,
  parameter int               RAS_DEPTH   = 4,
  parameter int               PC_STEP     = 4,
  parameter int               PIPE_OFFSET = 8,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic             link,
  input  logic             ret,
  input  logic [WIDTH-1:0] branch_imm,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] curr_pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic             misalign_err
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  localparam logic [WIDTH-1:0] STEP   = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] OFFSET = WIDTH'(PIPE_OFFSET);
  localparam logic [CW-1:0]    FULL_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] br_base;
  logic [WIDTH-1:0] br_mag;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] load_val;
  logic             load;
  logic [PW-1:0]    top_idx;
  logic             is_empty;
  logic             is_full;

  assign seq_pc   = pc_q + STEP;
  assign br_base  = pc_q + OFFSET;
  assign br_mag   = {1'b0, branch_imm[WIDTH-2:0]};
  assign br_tgt   = branch_imm[WIDTH-1] ? (br_base - br_mag) : (br_base + br_mag);
  // wp_q points at the next free slot, so the newest entry sits one below it;
  // the power-of-two depth makes the pointer wrap for free.
  assign top_idx  = wp_q - PW'(1);
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == FULL_C);

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q, mis_d;
`endif

  always_comb begin
    pc_d     = pc_q;
    ras_d    = ras_q;
    wp_d     = wp_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    load     = 1'b0;
    load_val = '0;
`ifdef PC_ALIGN_CHECK_EN
    mis_d    = 1'b0;
`endif
    if (!stall) begin
      if (branch) begin
        load     = 1'b1;
        load_val = br_tgt;
        if (link) begin
          // When full, slot wp_q holds the oldest entry, so writing there and
          // advancing the pointer overwrites it without touching the count.
          ras_d[wp_q] = seq_pc;
          wp_d        = wp_q + PW'(1);
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end else if (ret) begin
        if (is_empty) begin
          pc_d  = seq_pc;
          unf_d = 1'b1;
        end else begin
          load     = 1'b1;
          load_val = ras_q[top_idx];
          wp_d     = top_idx;
          cnt_d    = cnt_q - CW'(1);
        end
      end else if (write_enable) begin
        load     = 1'b1;
        load_val = write_data;
      end else begin
        pc_d = seq_pc;
      end

      if (load) begin
`ifdef PC_ALIGN_CHECK_EN
        pc_d  = {load_val[WIDTH-1:2], 2'b00};
        mis_d = |load_val[1:0];
`else
        pc_d  = load_val;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry contents need no reset: a zero count makes them unreachable.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
  assign misalign_err = mis_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign curr_pc       = pc_q;
  assign ras_empty     = is_empty;
  assign ras_full      = is_full;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - directed and randomized self-checking bench for pc_unit_ras

module tb_pc_unit_ras;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, stall, branch, link, ret, write_enable;
  logic [31:0] branch_imm, write_data;
  logic [31:0] curr_pc;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow, misalign_err;

  int total = 0;
  int bad   = 0;

  // Reference model: the RAS is a plain queue, newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_unf, m_mis;

  pc_unit_ras #(
    .WIDTH(32), .RAS_DEPTH(DEPTH), .PC_STEP(4), .PIPE_OFFSET(8), .RESET_VEC(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .link(link), .ret(ret),
    .branch_imm(branch_imm), .write_enable(write_enable), .write_data(write_data),
    .curr_pc(curr_pc), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_load(input logic [31:0] v);
`ifdef PC_ALIGN_CHECK_EN
    m_pc  = v & 32'hFFFF_FFFC;
    m_mis = (v[1:0] != 2'b00);
`else
    m_pc  = v;
`endif
  endtask

  task automatic model_step(input logic r, s, b, l, rt, input logic [31:0] imm,
                            input logic we, input logic [31:0] wd);
    logic [31:0] mag;
    m_mis = 1'b0;
    if (r) begin
      m_pc = 32'h0;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (b) begin
      mag = {1'b0, imm[30:0]};
      if (l) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(m_pc + 32'd4);
      end
      model_load(imm[31] ? (m_pc + 32'd8 - mag) : (m_pc + 32'd8 + mag));
    end else if (rt) begin
      if (m_ras.size() == 0) begin
        m_pc  = m_pc + 32'd4;
        m_unf = 1'b1;
      end else begin
        model_load(m_ras.pop_back());
      end
    end else if (we) begin
      model_load(wd);
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step(input string tag, input logic r, s, b, l, rt,
                      input logic [31:0] imm, input logic we, input logic [31:0] wd);
    reset = r; stall = s; branch = b; link = l; ret = rt;
    branch_imm = imm; write_enable = we; write_data = wd;
    model_step(r, s, b, l, rt, imm, we, wd);
    @(posedge clk);
    #1;
    chk({tag, ".pc"},    curr_pc,              m_pc);
    chk({tag, ".empty"}, 32'(ras_empty),       32'(m_ras.size() == 0));
    chk({tag, ".full"},  32'(ras_full),        32'(m_ras.size() == DEPTH));
    chk({tag, ".ovf"},   32'(ras_overflow),    32'(m_ovf));
    chk({tag, ".unf"},   32'(ras_underflow),   32'(m_unf));
    chk({tag, ".mis"},   32'(misalign_err),    32'(m_mis));
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic wr(input string tag, input logic [31:0] v);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, v);
  endtask

  initial begin
    logic [31:0] a_pc;
    m_pc = 32'h0; m_ovf = 1'b0; m_unf = 1'b0; m_mis = 1'b0;

    // reset then sequential fetch
    step("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_pc", curr_pc, 32'h0);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    idle("seq1"); chk("seq1_abs", curr_pc, 32'h4);
    idle("seq2"); chk("seq2_abs", curr_pc, 32'h8);
    idle("seq3"); chk("seq3_abs", curr_pc, 32'hC);

    // sign-magnitude branches
    wr("w100a", 32'h100);
    step("bneg", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0010, 1'b0, 32'h0);
    chk("bneg_abs", curr_pc, 32'hF8);
    wr("w100b", 32'h100);
    step("bpos", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0);
    chk("bpos_abs", curr_pc, 32'h118);

    // link and return
    wr("w200", 32'h200);
    step("bl", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0);
    chk("bl_abs", curr_pc, 32'h248);
    chk("bl_empty", 32'(ras_empty), 32'd0);
    idle("bl_idle");
    step("ret", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    chk("ret_abs", curr_pc, 32'h204);
    chk("ret_empty", 32'(ras_empty), 32'd1);

    // overflow: five linked branches from 0x1000..0x5000, then five rets
    for (int i = 1; i <= 5; i++) begin
      wr("ovw", 32'(i) << 12);
      step("ovbl", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    end
    chk("ov_flag", 32'(ras_overflow), 32'd1);
    chk("ov_full", 32'(ras_full), 32'd1);
    for (int i = 5; i >= 2; i--) begin
      step("ovret", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
      chk("ovret_abs", curr_pc, (32'(i) << 12) + 32'd4);
    end
    a_pc = curr_pc;
    step("uf", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    chk("uf_abs", curr_pc, 32'h2008);
    chk("uf_flag", 32'(ras_underflow), 32'd1);
    chk("ov_sticky", 32'(ras_overflow), 32'd1);

    // branch beats ret and write
    wr("w300", 32'h300);
    step("prio", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h500);
    chk("prio_abs", curr_pc, 32'h308);
    chk("prio_empty", 32'(ras_empty), 32'd1);

    // stall holds everything, reset overrides stall
    step("stl1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0);
    step("stl2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0);
    chk("stl_abs", curr_pc, 32'h308);
    chk("stl_empty", 32'(ras_empty), 32'd1);
    step("stlrst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stlrst_abs", curr_pc, 32'h0);
    chk("stlrst_unf", 32'(ras_underflow), 32'd0);

    // alignment handling of direct writes
    wr("w403", 32'h403);
`ifdef PC_ALIGN_CHECK_EN
    chk("al_abs", curr_pc, 32'h400);
    chk("al_mis", 32'(misalign_err), 32'd1);
`else
    chk("al_abs", curr_pc, 32'h403);
    chk("al_mis", 32'(misalign_err), 32'd0);
`endif
    idle("al_idle");
    chk("al_pulse", 32'(misalign_err), 32'd0);

    // modulo wrap of the sequential increment
    wr("wwrap", 32'hFFFF_FFFC);
    idle("wrap");
    chk("wrap_abs", curr_pc, 32'h0);

    // randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 2) == 0),
           {1'($urandom_range(0, 1)), 31'($urandom_range(0, 1023))},
           ($urandom_range(0, 3) == 0),
           $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
